hs_rr_arbiter: RTL and testbench
================================

Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready command slave (cmd/addr/data in, read data out) among NUM_REQ requesters.
- Serialises commands: one outstanding transaction at a time.
- Routes each read response back to the requester that issued the read.
- Sits between the requester masters and the existing `handshake` slave. A watchdog releases the bus if a read response never arrives.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WD, 4: data width.
- ADDR_WD, 4: address width.
- TIMEOUT, 64: max cycles in WAIT_RSP before abort (>=2).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept.
- req_cmd  in  NUM_REQ  per-requester cmd (1=write, 0=read).
- req_addr  in  NUM_REQ*ADDR_WD  packed addresses, requester i at [i*ADDR_WD +: ADDR_WD].
- req_data  in  NUM_REQ*DATA_WD  packed write data, same packing.
- rsp_valid  out  NUM_REQ  read-response valid, one-hot to the owner.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  DATA_WD  read data, shared by all requesters.
- m_valid  out  1  command valid to slave.
- m_ready  in  1  slave command ready.
- m_cmd  out  1  command cmd.
- m_addr  out  ADDR_WD  command address.
- m_data  out  DATA_WD  command write data.
- s_rsp_valid  in  1  slave read-response valid.
- s_rsp_ready  out  1  response accept to slave.
- s_rsp_data  in  DATA_WD  slave read data.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, rstn=0) forces:
  - state IDLE, rr_ptr=0, grant_idx=0, wd_cnt=0;
  - all outputs 0.
- FSM has three states: IDLE, CMD, WAIT_RSP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register the winner in grant_idx and go to CMD next cycle.
  - No req_valid set: stay in IDLE.
  - m_valid is 0 in IDLE.
- CMD:
  - m_valid = req_valid[grant_idx].
  - m_cmd/m_addr/m_data are muxed combinationally from the grant_idx fields.
  - req_ready[grant_idx] = m_ready; every other req_ready bit is 0.
  - Requesters must hold valid and fields until ready (standard rule). If req_valid[grant_idx] drops anyway, return to IDLE without a transfer; rr_ptr is unchanged.
  - On fire (m_valid & m_ready), rr_ptr <= (grant_idx+1) mod NUM_REQ.
    - Write (cmd=1): go to IDLE.
    - Read (cmd=0): go to WAIT_RSP and clear wd_cnt.
- WAIT_RSP:
  - rsp_valid[grant_idx] = s_rsp_valid; rsp_data = s_rsp_data; s_rsp_ready = rsp_ready[grant_idx].
  - Response fire returns to IDLE.
  - wd_cnt increments each cycle without a response fire.
  - When wd_cnt == TIMEOUT-1 and there is no fire: pulse timeout_err for one cycle, go to IDLE.
  - A fire in that same cycle wins: no error is raised.
- Outside WAIT_RSP, s_rsp_ready=0 and rsp_valid=0. A stray slave response is stalled, not dropped.
- Latency and throughput:
  - Request to m_valid: 1 cycle (IDLE then CMD).
  - Best-case write throughput: 1 per 2 cycles.
  - Read occupancy: 2 cycles plus slave latency plus response stall.
- Fairness: a requester that has just been granted has lowest priority next time. Any continuously asserting requester is granted within NUM_REQ transactions.
- Simultaneous events: new req_valid bits arriving while in CMD or WAIT_RSP are ignored until IDLE.
- Reset mid-transaction aborts immediately: no response is forwarded, and rr_ptr returns to 0.
- Width rules:
  - rr_ptr and grant_idx are $clog2(NUM_REQ) bits, with explicit wrap at NUM_REQ (correct for non-power-of-2 counts).
  - wd_cnt is $clog2(TIMEOUT) bits and saturates.

Decomposition:
- Shared package hs_pkg holds:
  - CMD_WR=1'b1, CMD_RD=1'b0;
  - the state enum (IDLE, CMD, WAIT_RSP);
  - the default widths.
- One sub-module, rr_pick: combinational first-set-bit search from a pointer, with wrap. Inputs req vector and ptr; outputs idx and any. It is reusable by other arbiters.

Test Plan:
- Single requester 0 writes addr 3 data 0xA with m_ready=1: m_valid rises 1 cycle after req_valid, m_addr=3, m_data=0xA, and req_ready[0] pulses once.
- All 4 requesters hold valid writes continuously with m_ready=1: grant order is 0,1,2,3,0,1, with one fire every 2 cycles.
- Requester 2 reads addr 5 and the slave returns 0x7 three cycles later: only rsp_valid[2]=1 and rsp_data=0x7. Requester 1's pending write stays stalled (req_ready[1]=0) until the response fires.
- Read with rsp_ready[owner]=0 for 5 cycles: s_rsp_ready stays 0, s_rsp_valid and data are held, then transfer completes when rsp_ready goes high.
- TIMEOUT=8, read issued, slave never responds: timeout_err pulses exactly 8 cycles after entering WAIT_RSP, and the FSM returns to IDLE to serve the next request.
- Assert rstn=0 during WAIT_RSP: all outputs go to 0 asynchronously. After release, a req on requester 1 (rr_ptr=0) is granted first.

Source files
------------

// File: rtl/hs_rr_arbiter_pkg.sv
// Shared definitions for the handshake round-robin arbiter: command encodings,
// FSM state type and default widths.
package hs_pkg;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_WD = 4;
  localparam int unsigned DEF_ADDR_WD = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Requester-side and slave-side handshake bundle of the arbiter.
// master: the arbiter's view; slave: the surrounding requesters/slave view.
interface hs_rr_arbiter_if
  import hs_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_WD = DEF_DATA_WD,
  parameter int unsigned ADDR_WD = DEF_ADDR_WD
);

  // requester command side
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_cmd;
  logic [NUM_REQ*ADDR_WD-1:0] req_addr;
  logic [NUM_REQ*DATA_WD-1:0] req_data;

  // requester response side
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [DATA_WD-1:0]         rsp_data;

  // shared slave command/response side
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_cmd;
  logic [ADDR_WD-1:0]         m_addr;
  logic [DATA_WD-1:0]         m_data;
  logic                       s_rsp_valid;
  logic                       s_rsp_ready;
  logic [DATA_WD-1:0]         s_rsp_data;

  modport master (
    input  req_valid, req_cmd, req_addr, req_data, rsp_ready,
           m_ready, s_rsp_valid, s_rsp_data,
    output req_ready, rsp_valid, rsp_data,
           m_valid, m_cmd, m_addr, m_data, s_rsp_ready
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_data, rsp_ready,
           m_ready, s_rsp_valid, s_rsp_data,
    input  req_ready, rsp_valid, rsp_data,
           m_valid, m_cmd, m_addr, m_data, s_rsp_ready
  );

endinterface

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req starting at ptr,
// wrapping past N-1 back to 0. Works for non-power-of-2 N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p,
                                             input int unsigned   off);
    int unsigned sum;
    sum = 32'(p) + off;
    if (sum >= N) sum = sum - N;
    return PW'(sum);
  endfunction

  always_comb begin
    logic [PW-1:0] cand;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = wrap_add(ptr, i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one valid/ready
// command slave, routing read responses to their owner, with a response watchdog.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_WD = DEF_DATA_WD,
  parameter int unsigned ADDR_WD = DEF_ADDR_WD,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstn,
  hs_rr_arbiter_if.master  bus,
  output logic             timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   grant_idx, grant_nxt;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic               timeout_nxt;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [ADDR_WD-1:0] addr_arr [NUM_REQ];
  logic [DATA_WD-1:0] data_arr [NUM_REQ];

  // Unpack per-requester fields so the grant mux is a plain array index
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*ADDR_WD +: ADDR_WD];
    assign data_arr[g] = bus.req_data[g*DATA_WD +: DATA_WD];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (IDX_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_idx   <= grant_nxt;
      wd_cnt      <= wd_cnt_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  // Next-state logic and handshake routing
  always_comb begin
    logic cmd_sel;
    logic rsp_fire;

    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = grant_idx;
    wd_cnt_nxt      = wd_cnt;
    timeout_nxt     = 1'b0;

    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_data    = '0;
    bus.m_valid     = 1'b0;
    bus.m_cmd       = 1'b0;
    bus.m_addr      = '0;
    bus.m_data      = '0;
    bus.s_rsp_ready = 1'b0;

    cmd_sel  = bus.req_cmd[grant_idx];
    rsp_fire = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = CMD;
        end
      end

      CMD: begin
        bus.m_valid              = bus.req_valid[grant_idx];
        bus.m_cmd                = cmd_sel;
        bus.m_addr               = addr_arr[grant_idx];
        bus.m_data               = data_arr[grant_idx];
        bus.req_ready[grant_idx] = bus.m_ready;
        if (!bus.req_valid[grant_idx]) begin
          state_nxt = IDLE;
        end else if (bus.m_ready) begin
          rr_ptr_nxt = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (cmd_sel == CMD_WR) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = WAIT_RSP;
            wd_cnt_nxt = '0;
          end
        end
      end

      WAIT_RSP: begin
        bus.rsp_valid[grant_idx] = bus.s_rsp_valid;
        bus.rsp_data             = bus.s_rsp_data;
        bus.s_rsp_ready          = bus.rsp_ready[grant_idx];
        rsp_fire                 = bus.s_rsp_valid & bus.rsp_ready[grant_idx];
        // A response in the last watchdog cycle still completes normally
        if (rsp_fire) begin
          state_nxt = IDLE;
        end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (wd_cnt != {CNT_W{1'b1}}) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed self-checking bench for hs_rr_arbiter (4 requesters, TIMEOUT=8).
module tb_hs_rr_arbiter;
  import hs_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rstn;
  logic timeout_err;
  int   checks   = 0;
  int   failures = 0;

  hs_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WD(DW), .ADDR_WD(AW)) bus ();

  hs_rr_arbiter #(
    .NUM_REQ (NR),
    .DATA_WD (DW),
    .ADDR_WD (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic cmd, input logic [3:0] addr,
                         input logic [3:0] data);
    bus.req_cmd[i]            = cmd;
    bus.req_addr[i*AW +: AW]  = addr;
    bus.req_data[i*DW +: DW]  = data;
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_cmd     = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.rsp_ready   = '0;
    bus.m_ready     = 1'b0;
    bus.s_rsp_valid = 1'b0;
    bus.s_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_watchdog got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pulses;
    logic fired;

    // reset state
    rstn = 1'b0;
    clear_inputs();
    #1;
    check("rst_m_valid",     32'(bus.m_valid), 0);
    check("rst_req_ready",   32'(bus.req_ready), 0);
    check("rst_rsp_valid",   32'(bus.rsp_valid), 0);
    check("rst_s_rsp_ready", 32'(bus.s_rsp_ready), 0);
    check("rst_timeout",     32'(timeout_err), 0);
    do_reset();

    // single write from requester 0
    bus.m_ready = 1'b1;
    set_req(0, CMD_WR, 4'h3, 4'hA);
    bus.req_valid = 4'b0001;
    #1;
    check("t1_idle_m_valid", 32'(bus.m_valid), 0);
    step();
    check("t1_m_valid",   32'(bus.m_valid), 1);
    check("t1_m_cmd",     32'(bus.m_cmd), 1);
    check("t1_m_addr",    32'(bus.m_addr), 32'h3);
    check("t1_m_data",    32'(bus.m_data), 32'hA);
    check("t1_req_ready", 32'(bus.req_ready), 32'b0001);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      fired = bus.req_valid[0] & bus.req_ready[0];
      if (bus.req_ready[0]) pulses++;
      step();
      if (fired) bus.req_valid[0] = 1'b0;
      #1;
    end
    check("t1_ready_pulses", 32'(pulses), 1);

    // all four requesters writing back-to-back
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, CMD_WR, 4'(i + 4), 4'(i + 1));
    bus.req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 6; n++) begin
      check("t2_idle_m_valid", 32'(bus.m_valid), 0);
      step();
      check("t2_m_valid",   32'(bus.m_valid), 1);
      check("t2_grant",     32'(bus.req_ready), 32'(1 << (n % 4)));
      check("t2_m_addr",    32'(bus.m_addr), 32'((n % 4) + 4));
      step();
    end

    // read from requester 2 with requester 1 write arriving later
    do_reset();
    bus.m_ready   = 1'b1;
    bus.rsp_ready = 4'b1111;
    set_req(2, CMD_RD, 4'h5, 4'h0);
    set_req(1, CMD_WR, 4'hE, 4'h6);
    bus.req_valid = 4'b0100;
    #1;
    step();
    bus.req_valid[1] = 1'b1;
    #1;
    check("t3_m_cmd",     32'(bus.m_cmd), 0);
    check("t3_m_addr",    32'(bus.m_addr), 32'h5);
    check("t3_req_ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid[2] = 1'b0;
    #1;
    check("t3_wait_req_ready", 32'(bus.req_ready), 0);
    check("t3_wait_m_valid",   32'(bus.m_valid), 0);
    check("t3_wait_rsp_valid", 32'(bus.rsp_valid), 0);
    step();
    step();
    step();
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data  = 4'h7;
    #1;
    check("t3_rsp_valid",   32'(bus.rsp_valid), 32'b0100);
    check("t3_rsp_data",    32'(bus.rsp_data), 32'h7);
    check("t3_s_rsp_ready", 32'(bus.s_rsp_ready), 1);
    check("t3_stall_req1",  32'(bus.req_ready), 0);
    step();
    bus.s_rsp_valid = 1'b0;
    #1;
    check("t3_after_rsp_valid", 32'(bus.rsp_valid), 0);
    step();
    check("t3_req1_grant", 32'(bus.req_ready), 32'b0010);
    check("t3_req1_addr",  32'(bus.m_addr), 32'hE);
    step();
    bus.req_valid[1] = 1'b0;
    #1;

    // read from requester 3 with owner holding off the response for 5 cycles
    set_req(3, CMD_RD, 4'h9, 4'h0);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 4'b0000;
    #1;
    step();
    check("t4_grant", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid   = 4'b0000;
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data  = 4'hC;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t4_stall_s_rsp_ready", 32'(bus.s_rsp_ready), 0);
      check("t4_stall_rsp_valid",   32'(bus.rsp_valid), 32'b1000);
      check("t4_stall_rsp_data",    32'(bus.rsp_data), 32'hC);
      step();
    end
    bus.rsp_ready = 4'b1000;
    #1;
    check("t4_s_rsp_ready", 32'(bus.s_rsp_ready), 1);
    step();
    bus.s_rsp_valid = 1'b0;
    #1;
    check("t4_done_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t4_no_timeout",     32'(timeout_err), 0);

    // read from requester 0 that never gets a response
    bus.rsp_ready = 4'b1111;
    set_req(0, CMD_RD, 4'h2, 4'h0);
    bus.req_valid = 4'b0001;
    #1;
    step();
    check("t5_grant", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = 4'b0000;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("t5_wait_timeout",     32'(timeout_err), 0);
      check("t5_wait_s_rsp_ready", 32'(bus.s_rsp_ready), 1);
      step();
    end
    check("t5_timeout_pulse",  32'(timeout_err), 1);
    check("t5_idle_s_rsp_rdy", 32'(bus.s_rsp_ready), 0);
    set_req(1, CMD_WR, 4'hB, 4'h4);
    bus.req_valid = 4'b0010;
    #1;
    step();
    check("t5_timeout_cleared", 32'(timeout_err), 0);
    check("t5_next_grant",      32'(bus.req_ready), 32'b0010);
    check("t5_next_addr",       32'(bus.m_addr), 32'hB);
    step();
    bus.req_valid = 4'b0000;
    #1;

    // reset asserted mid-read
    bus.rsp_ready = 4'b0000;
    set_req(2, CMD_RD, 4'h1, 4'h0);
    bus.req_valid = 4'b0100;
    #1;
    step();
    step();
    bus.req_valid   = 4'b0000;
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data  = 4'h5;
    #1;
    check("t6_pre_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
    rstn = 1'b0;
    #1;
    check("t6_rst_rsp_valid",   32'(bus.rsp_valid), 0);
    check("t6_rst_rsp_data",    32'(bus.rsp_data), 0);
    check("t6_rst_s_rsp_ready", 32'(bus.s_rsp_ready), 0);
    check("t6_rst_m_valid",     32'(bus.m_valid), 0);
    clear_inputs();
    step();
    rstn = 1'b1;
    bus.m_ready = 1'b1;
    set_req(1, CMD_WR, 4'h8, 4'h1);
    set_req(3, CMD_WR, 4'hD, 4'h2);
    bus.req_valid = 4'b1010;
    #1;
    step();
    check("t6_first_grant", 32'(bus.req_ready), 32'b0010);
    check("t6_first_addr",  32'(bus.m_addr), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
